// File: rtl/dpad_autorepeat.sv
// Held D-pad levels -> one-cycle step pulses with a press-to-repeat delay, then a fixed repeat rate.
// One-cycle registered latency, no backpressure; DPAD_ACCEL_EN halves the interval after ACCEL_AFTER repeats.
module dpad_autorepeat #(
  parameter int CNT_W        = 24,
  parameter int DELAY_CYCLES = 12000000,
  parameter int RATE_CYCLES  = 2500000,
  parameter int ACCEL_AFTER  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_udlr,
  output logic [3:0] step_udlr,
  output logic       repeating
);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DELAY_CYCLES);
  localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(RATE_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  if (DELAY_CYCLES < 2 || longint'(DELAY_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_delay
    $error("dpad_autorepeat: DELAY_CYCLES out of range");
  end
  if (RATE_CYCLES < 2 || longint'(RATE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_rate
    $error("dpad_autorepeat: RATE_CYCLES out of range");
  end
  if (ACCEL_AFTER < 0) begin : g_bad_accel
    $error("dpad_autorepeat: ACCEL_AFTER must be non-negative");
  end

  state_t           state_q [4];
  state_t           state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [CNT_W-1:0] ivl     [4];
  logic [3:0]       eff;
  logic [3:0]       step_d;
  logic             rep_d;

`ifdef DPAD_ACCEL_EN
  localparam int RPT_W = ($clog2(ACCEL_AFTER + 1) < 1) ? 1 : $clog2(ACCEL_AFTER + 1);
  localparam int FAST  = ((RATE_CYCLES >> 1) < 1) ? 1 : (RATE_CYCLES >> 1);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(ACCEL_AFTER);
  localparam logic [CNT_W-1:0] FAST_C  = CNT_W'(FAST);

  logic [RPT_W-1:0] rpt_q [4];
  logic [RPT_W-1:0] rpt_d [4];
`endif

  // Opposing pairs cancel: {up,down} = bits 3:2, {left,right} = bits 1:0.
  assign eff = {btn_udlr[3] & ~btn_udlr[2], btn_udlr[2] & ~btn_udlr[3],
                btn_udlr[1] & ~btn_udlr[0], btn_udlr[0] & ~btn_udlr[1]};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ivl[i] = RATE_C;
`ifdef DPAD_ACCEL_EN
      if (rpt_q[i] >= RPT_MAX) ivl[i] = FAST_C;
`endif
    end
  end

  always_comb begin
    rep_d  = 1'b0;
    step_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef DPAD_ACCEL_EN
      rpt_d[i]   = rpt_q[i];
`endif
      case (state_q[i])
        IDLE: begin
          if (eff[i]) begin
            state_d[i] = DELAY;
            cnt_d[i]   = ONE_C;
            step_d[i]  = 1'b1;
          end
        end
        DELAY: begin
          if (!eff[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DELAY_C) begin
            state_d[i] = REPEAT;
            cnt_d[i]   = ONE_C;
            step_d[i]  = 1'b1;
`ifdef DPAD_ACCEL_EN
            rpt_d[i]   = RPT_W'(1);
`endif
          end else begin
            cnt_d[i]   = cnt_q[i] + ONE_C;
          end
        end
        REPEAT: begin
          // Release is checked first so a release on a repeat boundary emits nothing.
          if (!eff[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
`ifdef DPAD_ACCEL_EN
            rpt_d[i]   = '0;
`endif
          end else if (cnt_q[i] == ivl[i]) begin
            cnt_d[i]   = ONE_C;
            step_d[i]  = 1'b1;
`ifdef DPAD_ACCEL_EN
            if (rpt_q[i] < RPT_MAX) rpt_d[i] = rpt_q[i] + RPT_W'(1);
`endif
          end else begin
            cnt_d[i]   = cnt_q[i] + ONE_C;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      rep_d = rep_d | (state_d[i] == REPEAT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
`ifdef DPAD_ACCEL_EN
        rpt_q[i]   <= '0;
`endif
      end
      step_udlr <= 4'b0000;
      repeating <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef DPAD_ACCEL_EN
        rpt_q[i]   <= rpt_d[i];
`endif
      end
      step_udlr <= step_d;
      repeating <= rep_d;
    end
  end

endmodule

// File: tb/tb_dpad_autorepeat.sv
// Table-driven bench for dpad_autorepeat (DELAY=10, RATE=4, ACCEL_AFTER=3, CNT_W=8),
// plus hand-written reset sequences.
module tb_dpad_autorepeat;

  localparam int CNT_W = 8;
  localparam int DELAY = 10;
  localparam int RATE  = 4;
  localparam int ACCEL = 3;

  // Expected step edges (relative to press edge) for a 30-cycle hold.
`ifdef DPAD_ACCEL_EN
  localparam logic [63:0] HOLD30_MASK = 64'h0000_0000_1554_4401; // 0,10,14,18,20,22,24,26,28
`else
  localparam logic [63:0] HOLD30_MASK = 64'h0000_0000_0444_4401; // 0,10,14,18,22,26
`endif
  localparam logic [63:0] HOLD19_MASK = 64'h0000_0000_0004_4401; // 0,10,14,18
  localparam logic [63:0] HOLD14_MASK = 64'h0000_0000_0000_0401; // 0,10
  localparam int NO_REP = 999;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_udlr = 4'b0000;
  logic [3:0] step_udlr;
  logic       repeating;

  int n_tests = 0;
  int n_fail  = 0;

  dpad_autorepeat #(
    .CNT_W(CNT_W), .DELAY_CYCLES(DELAY), .RATE_CYCLES(RATE), .ACCEL_AFTER(ACCEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_udlr(btn_udlr),
    .step_udlr(step_udlr), .repeating(repeating)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] exp_step;
    logic       exp_rep;
    int         grp;
    int         idx;
  } vec_t;

  vec_t  vecs[$];
  string gname [7] = '{"idle", "tap", "hold_right", "opposing", "up_after_opp",
                       "boundary", "diagonal"};

  function automatic void add(int grp, int idx, logic [3:0] b, logic [3:0] s, logic r);
    vec_t v;
    v.btn = b; v.exp_step = s; v.exp_rep = r; v.grp = grp; v.idx = idx;
    vecs.push_back(v);
  endfunction

  // n cycles of btn held; pulse on pbits at edges set in pmask; repeating from rep_from on.
  function automatic void add_hold(int grp, logic [3:0] b, int n, logic [63:0] pmask,
                                   logic [3:0] pbits, int rep_from);
    for (int j = 0; j < n; j++)
      add(grp, j, b, pmask[j] ? pbits : 4'b0000, (j >= rep_from));
  endfunction

  task automatic check(string nm, logic [3:0] s, logic r);
    n_tests++;
    if ({step_udlr, repeating} !== {s, r}) begin
      n_fail++;
      $display("FAIL %s: got step_udlr=%b repeating=%b, expected step_udlr=%b repeating=%b",
               nm, step_udlr, repeating, s, r);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table
    add_hold(0, 4'b0000, 3, 64'h0, 4'b0000, NO_REP);
    add_hold(1, 4'b0001, 1, 64'h1, 4'b0001, NO_REP);
    add_hold(1, 4'b0000, 50, 64'h0, 4'b0000, NO_REP);
    add_hold(2, 4'b0001, 30, HOLD30_MASK, 4'b0001, 10);
    add(2, 30, 4'b0000, 4'b0000, 1'b0);
    add(2, 31, 4'b0000, 4'b0000, 1'b0);
    add_hold(3, 4'b1100, 40, 64'h0, 4'b0000, NO_REP);
    add_hold(4, 4'b1000, 19, HOLD19_MASK, 4'b1000, 10);
    add(4, 19, 4'b0000, 4'b0000, 1'b0);
    add_hold(5, 4'b0001, 14, HOLD14_MASK, 4'b0001, 10);
    add(5, 14, 4'b0000, 4'b0000, 1'b0);
    add_hold(5, 4'b0001, 11, HOLD14_MASK, 4'b0001, 10);
    add(5, 99, 4'b0000, 4'b0000, 1'b0);
    add_hold(6, 4'b1001, 11, HOLD14_MASK, 4'b1001, 10);
    add(6, 11, 4'b0000, 4'b0000, 1'b0);

    // Reset with all buttons held
    rst_n    = 1'b0;
    btn_udlr = 4'b1111;
    repeat (3) tick();
    check("reset_held", 4'b0000, 1'b0);
    tick();
    check("reset_held2", 4'b0000, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      btn_udlr = vecs[i].btn;
      tick();
      check($sformatf("%s[%0d]", gname[vecs[i].grp], vecs[i].idx),
            vecs[i].exp_step, vecs[i].exp_rep);
    end

    // Mid-hold reset: assert just after the first repeat pulse, between edges
    btn_udlr = 4'b0010;
    for (int j = 0; j <= 10; j++) begin
      tick();
      check($sformatf("midrst_hold[%0d]", j),
            (j == 0 || j == 10) ? 4'b0010 : 4'b0000, (j == 10));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_async_clear", 4'b0000, 1'b0);
    tick();
    check("midrst_in_reset", 4'b0000, 1'b0);
    rst_n = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      tick();
      check($sformatf("midrst_after[%0d]", j),
            (j == 0 || j == 10) ? 4'b0010 : 4'b0000, (j == 10));
    end
    btn_udlr = 4'b0000;
    tick();
    check("midrst_release", 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
